// File: rtl/result_pkg.sv
// Shared types and constants for the result read-back UART.
package result_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      LOAD,
      START,
      DATA,
      STOP,
      NEXT,
      FIN
   } tx_state_t;

   localparam int NUM_WORDS      = 8;
   localparam int BYTES_PER_WORD = 4;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   // Word 0 is element1, so byte n of the stream is little-endian within its word
   typedef logic [NUM_WORDS-1:0][31:0] word_buf_t;

   // Returns data byte n (0..31) of the snapshot, element1 first, bits 7:0 first
   function automatic logic [7:0] pick_byte(input word_buf_t words, input logic [4:0] n);
      return words[n[4:2]][{n[1:0], 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Result bus and status lines between the core side and the read-back UART.
interface result_uart_tx_if;
   import result_pkg::*;

   logic        start;
   logic        stall;
   logic        flush;
   logic [31:0] element1;
   logic [31:0] element2;
   logic [31:0] element3;
   logic [31:0] element4;
   logic [31:0] element5;
   logic [31:0] element6;
   logic [31:0] element7;
   logic [31:0] element8;
   logic        tx;
   logic        busy;
   logic        done;
   logic [5:0]  byte_idx;

   modport master (
      output start, stall, flush,
      output element1, element2, element3, element4,
      output element5, element6, element7, element8,
      input  tx, busy, done, byte_idx
   );

   modport slave (
      input  start, stall, flush,
      input  element1, element2, element3, element4,
      input  element5, element6, element7, element8,
      output tx, busy, done, byte_idx
   );

endinterface

// File: rtl/result_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, one stop bit.
module uart_tx_byte
   import result_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx,
   output logic       frame_end
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   tx_state_t     phase;
   logic [BW-1:0] baud;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          wrap;

   assign wrap      = (baud == BAUD_MAX);
   assign ready     = (phase == IDLE);
   assign frame_end = (phase == STOP) && wrap;

   // Walks one frame; tx is a flop so the line never glitches between bits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         case (phase)
            IDLE: begin
               if (valid) begin
                  shreg   <= data;
                  tx      <= 1'b0;
                  baud    <= '0;
                  bit_cnt <= '0;
                  phase   <= START;
               end
            end
            START: begin
               if (wrap) begin
                  baud  <= '0;
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                  phase <= DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (wrap) begin
                  baud <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     phase <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            STOP: begin
               if (wrap) begin
                  baud  <= '0;
                  phase <= IDLE;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               phase <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/result_uart_tx.sv
// Snapshots the core's eight result words once the pipeline is quiet and
// streams them (optionally behind a sync byte) out of a UART line.
module result_uart_tx
   import result_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 868,
   parameter int         HEADER_EN    = 1,
   parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER
) (
   input  logic           clk,
   input  logic           reset,
   result_uart_tx_if.slave bus
);

   localparam int         TOTAL_BYTES = NUM_WORDS * BYTES_PER_WORD + HEADER_EN;
   localparam logic [5:0] LAST_IDX    = 6'(TOTAL_BYTES - 1);
   localparam logic [5:0] HDR_OFFSET  = 6'(HEADER_EN);

   tx_state_t  state;
   word_buf_t  snap;
   word_buf_t  live_words;
   logic       busy_q;
   logic       done_q;
   logic [5:0] byte_idx_q;
   logic [4:0] next_data_n;

   logic       ser_valid;
   logic [7:0] ser_data;
   logic       ser_ready;
   logic       ser_tx;
   logic       ser_frame_end;

   assign live_words  = {bus.element8, bus.element7, bus.element6, bus.element5,
                         bus.element4, bus.element3, bus.element2, bus.element1};
   assign next_data_n = 5'(byte_idx_q + 6'd1 - HDR_OFFSET);

   // Hands the serialiser its next byte: the first one straight from LOAD so
   // the start bit lands on the following edge, later ones from the snapshot
   always_comb begin
      ser_valid = 1'b0;
      ser_data  = 8'h00;
      case (state)
         LOAD: begin
            ser_valid = 1'b1;
            ser_data  = (HEADER_EN != 0) ? HEADER_BYTE : pick_byte(live_words, 5'd0);
         end
         NEXT: begin
            if (byte_idx_q != LAST_IDX) begin
               ser_valid = 1'b1;
               ser_data  = pick_byte(snap, next_data_n);
            end
         end
         default: begin
         end
      endcase
   end

   // Sequencer: waits for a quiet pipeline, captures, then counts bytes out;
   // it sits in START while the serialiser walks its own START/DATA/STOP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         snap       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         byte_idx_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  state  <= ARM;
               end
            end
            ARM: begin
               if (!bus.stall && !bus.flush) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               snap <= live_words;
               if (ser_ready) begin
                  state <= START;
               end
            end
            START: begin
               if (ser_frame_end) begin
                  state <= NEXT;
               end
            end
            NEXT: begin
               if (byte_idx_q == LAST_IDX) begin
                  byte_idx_q <= '0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state      <= FIN;
               end else if (ser_ready) begin
                  byte_idx_q <= byte_idx_q + 6'd1;
                  state      <= START;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk       (clk),
      .reset     (reset),
      .valid     (ser_valid),
      .data      (ser_data),
      .ready     (ser_ready),
      .tx        (ser_tx),
      .frame_end (ser_frame_end)
   );

   assign bus.tx       = ser_tx;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.byte_idx = byte_idx_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: decodes the UART line and compares the bytes and
// timing against a byte-stream model built from the words that were applied.
module tb_result_uart_tx;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   nCompared = 0;
   int   nMismatched = 0;
   int   doneA = 0;
   int   doneB = 0;

   logic [31:0] elemA [8];
   logic [31:0] elemB [8];
   logic [7:0]  expQ [$];

   result_uart_tx_if bus_a ();
   result_uart_tx_if bus_b ();

   assign bus_a.element1 = elemA[0];
   assign bus_a.element2 = elemA[1];
   assign bus_a.element3 = elemA[2];
   assign bus_a.element4 = elemA[3];
   assign bus_a.element5 = elemA[4];
   assign bus_a.element6 = elemA[5];
   assign bus_a.element7 = elemA[6];
   assign bus_a.element8 = elemA[7];
   assign bus_b.element1 = elemB[0];
   assign bus_b.element2 = elemB[1];
   assign bus_b.element3 = elemB[2];
   assign bus_b.element4 = elemB[3];
   assign bus_b.element5 = elemB[4];
   assign bus_b.element6 = elemB[5];
   assign bus_b.element7 = elemB[6];
   assign bus_b.element8 = elemB[7];

   result_uart_tx #(.CLKS_PER_BIT(4), .HEADER_EN(1), .HEADER_BYTE(8'hA5)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave));

   result_uart_tx #(.CLKS_PER_BIT(2), .HEADER_EN(0), .HEADER_BYTE(8'hA5)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave));

   // Free-running clock and a cycle count of rising edges
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Counts done pulses per instance
   always @(negedge clk) begin
      if (bus_a.done === 1'b1) doneA++;
      if (bus_b.done === 1'b1) doneB++;
   end

   function automatic logic getTx(input int sel);
      return (sel != 0) ? bus_b.tx : bus_a.tx;
   endfunction

   function automatic logic getBusy(input int sel);
      return (sel != 0) ? bus_b.busy : bus_a.busy;
   endfunction

   function automatic logic getDone(input int sel);
      return (sel != 0) ? bus_b.done : bus_a.done;
   endfunction

   function automatic logic [5:0] getIdx(input int sel);
      return (sel != 0) ? bus_b.byte_idx : bus_a.byte_idx;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Pulses start for one cycle; returns the cycle count at which it was raised
   task automatic applyStimulus(input int sel, output int startCyc);
      startCyc = cyc;
      if (sel != 0) bus_b.start = 1'b1; else bus_a.start = 1'b1;
      @(negedge clk);
      if (sel != 0) bus_b.start = 1'b0; else bus_a.start = 1'b0;
   endtask

   task automatic randomizeElems(input int sel);
      for (int i = 0; i < 8; i++) begin
         if (sel != 0) elemB[i] = $urandom; else elemA[i] = $urandom;
      end
   endtask

   // Reference byte stream: optional sync byte, then each word low byte first
   task automatic buildExpected(input int sel, input bit hdr);
      logic [31:0] word;
      expQ.delete();
      if (hdr) expQ.push_back(8'hA5);
      for (int w = 0; w < 8; w++) begin
         word = (sel != 0) ? elemB[w] : elemA[w];
         for (int b = 0; b < 4; b++) expQ.push_back(8'((word >> (8 * b)) % 256));
      end
   endtask

   // Waits for a start bit and samples every cycle of the 10-bit frame
   task automatic readByte(input int sel, input int c, output logic [7:0] b,
                           output int fallCyc, output logic [5:0] idx, output int bad);
      int   waited;
      logic bits [10];
      waited  = 0;
      b       = '0;
      idx     = '0;
      bad     = 0;
      fallCyc = -1;
      while (getTx(sel) !== 1'b0 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (getTx(sel) !== 1'b0) begin
         bad = 1;
         return;
      end
      fallCyc = cyc;
      idx     = getIdx(sel);
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < c; j++) begin
            if (!(k == 0 && j == 0)) @(negedge clk);
            if (j == 0) bits[k] = getTx(sel);
            else if (getTx(sel) !== bits[k]) bad++;
         end
      end
      if (bits[0] !== 1'b0) bad++;
      if (bits[9] !== 1'b1) bad++;
      for (int i = 0; i < 8; i++) b[i] = bits[i + 1];
   endtask

   // Decodes a whole transmission and checks bytes, spacing, done timing and idle after
   task automatic runSequence(input int sel, input int c, input int n, input int startCyc,
                              input int expLat, input int changeAt, input int pokeAt, input bit finPoke);
      logic [7:0] b;
      logic [5:0] idx;
      int fall, first, prev, bad, w, d0, dummy;
      int gapErr, widthErr, idxErr, idleErr;
      gapErr = 0; widthErr = 0; idxErr = 0; idleErr = 0; first = 0; prev = 0;
      d0 = (sel != 0) ? doneB : doneA;
      for (int i = 0; i < n; i++) begin
         readByte(sel, c, b, fall, idx, bad);
         if (fall < 0) begin
            checkOutput("frame_timeout", i, n);
            break;
         end
         widthErr += bad;
         if (idx !== 6'(i)) idxErr++;
         if (i == 0) begin
            checkOutput("latency", fall - startCyc, expLat);
            first = fall;
         end else if (fall - prev != 10 * c + 1) begin
            gapErr++;
         end
         prev = fall;
         checkOutput($sformatf("byte%0d", i), b, expQ[i]);
         if (i == changeAt) elemA[7] = 32'h0;
         if (i == pokeAt) applyStimulus(sel, dummy);
      end
      checkOutput("bit_width", widthErr, 0);
      checkOutput("frame_gap", gapErr, 0);
      checkOutput("byte_idx_seq", idxErr, 0);
      w = 0;
      while (getDone(sel) !== 1'b1 && w < 8 * c + 20) begin
         @(negedge clk);
         w++;
      end
      checkOutput("done_time", cyc - first, n * (10 * c + 1));
      checkOutput("busy_fin", getBusy(sel), 1'b0);
      checkOutput("idx_fin", getIdx(sel), 6'd0);
      if (finPoke) applyStimulus(sel, dummy);
      repeat (60) begin
         @(negedge clk);
         if (getTx(sel) !== 1'b1 || getBusy(sel) !== 1'b0) idleErr++;
      end
      checkOutput("idle_after", idleErr, 0);
      checkOutput("done_count", ((sel != 0) ? doneB : doneA) - d0, 1);
   endtask

   // Stops a runaway simulation with a failure and the summary
   initial begin
      #1_000_000;
      nMismatched++;
      $display("[TB] FAIL watchdog: observed timeout, expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   // Directed and randomized scenarios
   initial begin
      int s, d, holdErr, w, fall, bad;
      logic [7:0] b;
      logic [5:0] idx;
      reset = 1'b0;
      bus_a.start = 1'b0; bus_a.stall = 1'b0; bus_a.flush = 1'b0;
      bus_b.start = 1'b0; bus_b.stall = 1'b0; bus_b.flush = 1'b0;
      for (int i = 0; i < 8; i++) begin
         elemA[i] = 32'h0;
         elemB[i] = 32'h0;
      end
      repeat (3) @(negedge clk);
      checkOutput("rst_tx", bus_a.tx, 1'b1);
      checkOutput("rst_busy", bus_a.busy, 1'b0);
      checkOutput("rst_done", bus_a.done, 1'b0);
      checkOutput("rst_idx", bus_a.byte_idx, 6'd0);
      checkOutput("rst_tx_b", bus_b.tx, 1'b1);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] basic frame");
      elemA[0] = 32'h04030201;
      buildExpected(0, 1'b1);
      applyStimulus(0, s);
      checkOutput("busy_on", bus_a.busy, 1'b1);
      runSequence(0, 4, 33, s, 3, -1, -1, 1'b0);

      for (int pass = 0; pass < 2; pass++) begin
         $display("[TB] capture hold-off pass %0d", pass);
         randomizeElems(0);
         if (pass == 0) bus_a.stall = 1'b1; else bus_a.flush = 1'b1;
         applyStimulus(0, s);
         holdErr = 0;
         repeat (20) begin
            if (bus_a.tx !== 1'b1 || bus_a.busy !== 1'b1) holdErr++;
            @(negedge clk);
         end
         checkOutput((pass == 0) ? "holdoff_stall" : "holdoff_flush", holdErr, 0);
         randomizeElems(0);
         buildExpected(0, 1'b1);
         bus_a.stall = 1'b0;
         bus_a.flush = 1'b0;
         d = cyc;
         runSequence(0, 4, 33, d, 2, -1, -1, 1'b0);
      end

      $display("[TB] snapshot isolation and start while busy");
      randomizeElems(0);
      elemA[7] = 32'hDEADBEEF;
      buildExpected(0, 1'b1);
      applyStimulus(0, s);
      runSequence(0, 4, 33, s, 3, 5, 12, 1'b1);

      $display("[TB] reset mid-frame");
      randomizeElems(0);
      applyStimulus(0, s);
      for (int i = 0; i < 10; i++) readByte(0, 4, b, fall, idx, bad);
      w = 0;
      while (bus_a.tx !== 1'b0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      repeat (6) @(negedge clk);
      checkOutput("pre_rst_busy", bus_a.busy, 1'b1);
      reset = 1'b0;
      #1;
      checkOutput("abort_tx", bus_a.tx, 1'b1);
      checkOutput("abort_busy", bus_a.busy, 1'b0);
      checkOutput("abort_idx", bus_a.byte_idx, 6'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      randomizeElems(0);
      buildExpected(0, 1'b1);
      applyStimulus(0, s);
      runSequence(0, 4, 33, s, 3, -1, -1, 1'b0);

      $display("[TB] header disabled");
      randomizeElems(1);
      buildExpected(1, 1'b0);
      applyStimulus(1, s);
      runSequence(1, 2, 32, s, 3, -1, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Read-back end of the pipelined core's result bus: snapshots the eight 32-bit result words (element1..element8) and serialises them off-chip over a UART 8N1 transmit line.
- Sits beside the core at the FPGA top level, in place of the simulation bench, so the same results can be checked on hardware by a host.
- Capture waits until the pipeline is quiescent: stall=0 and flush=0.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- HEADER_EN, 1: when 1, a sync byte is sent before the data.
- HEADER_BYTE, 8'hA5: value of the sync byte.

Ports:
- clk  input  1: system clock, rising edge.
- reset  input  1: asynchronous, active-low reset.
- start  input  1: single-cycle request to capture and send.
- element1 .. element8  input  32 each: result words from the core.
- stall  input  1: core pipeline stall indicator.
- flush  input  1: core pipeline flush indicator.
- tx  output  1: UART serial out; idle level is high.
- busy  output  1: high from accepted start until done.
- done  output  1: one-cycle pulse after the last stop bit.
- byte_idx  output  6: index of the byte currently on the line. 0 is the header if enabled. Intended for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, done=0, byte_idx=0.
  - State goes to IDLE; baud counter and bit counter clear; snapshot buffer clears.
  - Reset applied mid-frame aborts the frame immediately. No partial stop bit is completed.
- States: IDLE, ARM, LOAD, START, DATA, STOP, NEXT, FIN.
- IDLE:
  - start=1 moves to ARM and sets busy=1 on the next edge.
  - start while busy=1 is ignored and not queued.
- ARM: stays in ARM while stall or flush is high; otherwise moves to LOAD.
- LOAD (one cycle):
  - Registers all eight words into an internal 8x32 buffer.
  - Total byte count = 32 + HEADER_EN.
  - Word/byte order: element1 first, each word little-endian (bits 7:0 first).
  - Input changes after LOAD do not affect transmission.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles.
- NEXT (one cycle, tx=1):
  - Increments byte_idx.
  - If bytes remain, goes to START; otherwise goes to FIN.
- Timing consequences:
  - Each byte frame occupies 10*CLKS_PER_BIT + 1 cycles, counting the NEXT gap.
  - Latency from accepted start to first falling edge of tx is 3 cycles when stall=flush=0: IDLE→ARM, ARM→LOAD, LOAD→START.
- FIN (one cycle):
  - done=1, busy=0, byte_idx returns to 0, then goes to IDLE.
  - start asserted during FIN is ignored.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; a bit boundary occurs at the wrap.
- Bit counter: 3 bits, counts 0..7.
- tx is driven from a register, so the line is glitch-free.

Decomposition:
- Shared package (result_pkg):
  - State enum (tx_state_t).
  - NUM_WORDS=8 and BYTES_PER_WORD=4.
  - Default header value.
- One natural sub-module, uart_tx_byte: the byte serialiser.
  - Handshake: valid/ready in, 8-bit data in, tx out, CLKS_PER_BIT parameter.
  - The top keeps IDLE/ARM/LOAD/NEXT/FIN plus the buffer and byte sequencing.

Test Plan:
- Basic frame:
  - Stimulus: CLKS_PER_BIT=4, HEADER_EN=1, element1=32'h04030201, others 0. Pulse start with stall=flush=0.
  - Required: first tx falling edge 3 cycles after start. Decoded bytes are A5,01,02,03,04 then 28 zeros.
  - Required: done pulses 33*41 cycles after the first start bit; busy falls with done.
- Capture hold-off:
  - Stimulus: hold stall=1 for 20 cycles after start.
  - Required: tx stays 1 and busy=1 throughout; capture occurs on the first cycle with stall=0 and flush=0.
  - Same check repeated with flush.
- Snapshot isolation:
  - Stimulus: change element8 from 32'hDEADBEEF to 0 during byte 5.
  - Required: last four bytes are EF,BE,AD,DE.
- Start while busy:
  - Stimulus: pulse start again mid-transmission and again during FIN.
  - Required: exactly one done pulse; no second transmission.
- Reset mid-frame:
  - Stimulus: assert reset during the DATA bits of byte 10.
  - Required: tx=1 and busy=0 immediately, asynchronously. A new start after release sends a full 33-byte sequence from the header.
- Header disabled:
  - Stimulus: HEADER_EN=0, CLKS_PER_BIT=2.
  - Required: 32 bytes, each bit 2 cycles wide; first byte is element1[7:0].
